// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the ID/EX pipeline datapath and the forwarding/hazard controller.
// The datapath (master) presents the decoded ID instruction and receives the mux selects and stall.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned CNT_BITS = 16
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rn;
  logic [REG_BITS-1:0] id_rm;
  logic                id_use_rn;
  logic                id_use_rm;
  logic [REG_BITS-1:0] id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic [1:0]          fwd_sel_a;
  logic [1:0]          fwd_sel_b;
  logic                stall;
  logic [CNT_BITS-1:0] stall_count;

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_reg_write, id_mem_read, flush,
    input  fwd_sel_a, fwd_sel_b, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_reg_write, id_mem_read, flush,
    output fwd_sel_a, fwd_sel_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows rd/rn/rm of in-flight instructions in EX/MEM/WB and drives operand mux selects and stall.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_BITS = 16
) (
  input logic             clk,
  input logic             reset,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [REG_BITS-1:0] XZR     = REG_BITS'(ZERO_REG);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef logic [REG_BITS-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic reg_write;
    logic mem_read;
  } stage_t;

  typedef struct packed {
    stage_t dst;
    reg_t   rn;
    reg_t   rm;
    logic   use_rn;
    logic   use_rm;
  } ex_t;

  ex_t                 ex_q;
  ex_t                 ex_d;
  stage_t              mem_q;
  stage_t              wb_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic       load_in_ex_c;
  logic       rn_hit_c;
  logic       rm_hit_c;
  logic       stall_c;
  logic       bubble_c;
  logic [1:0] sel_a_c;
  logic [1:0] sel_b_c;
  logic       unused_wb_mem_read;

  // A stage is a forwarding source for r only if it really writes a non-zero register.
  function automatic logic writes(input stage_t s, input reg_t r);
    return s.valid && s.reg_write && (s.rd == r) && (s.rd != XZR);
  endfunction

  // Newest producer wins: MEM before WB, otherwise read the register file.
  function automatic logic [1:0] pick_src(input logic ex_valid, input logic use_r,
                                          input reg_t r, input stage_t mem_s,
                                          input stage_t wb_s);
    if (!ex_valid || !use_r || (r == XZR)) return SEL_RF;
    if (writes(mem_s, r))                  return SEL_MEM;
    if (writes(wb_s, r))                   return SEL_WB;
    return SEL_RF;
  endfunction

  always_comb begin
    sel_a_c = pick_src(ex_q.dst.valid, ex_q.use_rn, ex_q.rn, mem_q, wb_q);
    sel_b_c = pick_src(ex_q.dst.valid, ex_q.use_rm, ex_q.rm, mem_q, wb_q);
  end

  // Load in EX whose result the ID instruction needs next cycle; flush overrides.
  always_comb begin
    load_in_ex_c = ex_q.dst.valid && ex_q.dst.mem_read && ex_q.dst.reg_write &&
                   (ex_q.dst.rd != XZR);
    rn_hit_c     = bus.id_use_rn && (bus.id_rn == ex_q.dst.rd);
    rm_hit_c     = bus.id_use_rm && (bus.id_rm == ex_q.dst.rd);
    stall_c      = bus.id_valid && !bus.flush && load_in_ex_c && (rn_hit_c || rm_hit_c);
    bubble_c     = stall_c || bus.flush;
  end

  // Next EX record: the ID instruction, or an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (!bubble_c) begin
      ex_d.dst.valid     = bus.id_valid;
      ex_d.dst.rd        = bus.id_rd;
      ex_d.dst.reg_write = bus.id_reg_write;
      ex_d.dst.mem_read  = bus.id_mem_read;
      ex_d.rn            = bus.id_rn;
      ex_d.rm            = bus.id_rm;
      ex_d.use_rn        = bus.id_use_rn;
      ex_d.use_rm        = bus.id_use_rm;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.dst;
      wb_q  <= mem_q;
      if (stall_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
    end
  end

  // WB's load flag is carried for completeness but nothing downstream consumes it.
  assign unused_wb_mem_read = wb_q.mem_read;

  assign bus.fwd_sel_a   = sel_a_c;
  assign bus.fwd_sel_b   = sel_b_c;
  assign bus.stall       = stall_c;
  assign bus.stall_count = cnt_q;

  a_sel_a_legal : assert property (@(posedge clk) disable iff (!reset) sel_a_c != 2'b11);
  a_sel_b_legal : assert property (@(posedge clk) disable iff (!reset) sel_b_c != 2'b11);

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipelined CPU.
- Tracks destination registers of in-flight instructions across the EX, MEM and WB stages.
- Drives the 2-bit selects of the two 64-bit 3:1 ALU-operand muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Detects load-use hazards, requests a one-cycle stall, and inserts a bubble into EX.

Parameters:
REG_BITS, 5, width of register specifiers
ZERO_REG, 31, hard-wired zero register (XZR); never a forwarding source, never causes a stall
CNT_BITS, 16, width of saturating stall counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
id_valid  input  1  ID-stage instruction is valid
id_rn  input  REG_BITS  ID first source register
id_rm  input  REG_BITS  ID second source register
id_use_rn  input  1  ID instruction reads rn
id_use_rm  input  1  ID instruction reads rm
id_rd  input  REG_BITS  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load (LDUR)
flush  input  1  branch taken; kill the ID-stage instruction
fwd_sel_a  output  2  select for operand-A 3:1 mux (EX instruction's rn)
fwd_sel_b  output  2  select for operand-B 3:1 mux (EX instruction's rm)
stall  output  1  hold PC and IF/ID this cycle
stall_count  output  CNT_BITS  number of stall cycles since reset, saturating

Behaviour:
- Internal stage records EX, MEM, WB. Each holds {valid, rd, reg_write, mem_read}; EX also holds {rn, rm, use_rn, use_rm}.
- Every rising edge: WB <= MEM; MEM <= EX; EX <= ID-stage fields.
  - EX instead loads a bubble (valid=0) when stall=1 or flush=1.
- Writer qualifier: a stage "writes r" iff valid & reg_write & rd==r & rd!=ZERO_REG.
- fwd_sel_a is combinational from registered state, so it is valid throughout the EX cycle. Evaluate in priority order:
  - 00 if EX.use_rn=0, EX.valid=0, or EX.rn==ZERO_REG.
  - else 01 if MEM writes EX.rn (the newer producer wins).
  - else 10 if WB writes EX.rn.
  - else 00.
- fwd_sel_b: identical rules using EX.rm / EX.use_rm.
- Value 11 is never driven.
- stall is combinational. It is 1 iff all of the following hold:
  - id_valid=1 and flush=0;
  - EX.valid & EX.mem_read & EX.reg_write and EX.rd!=ZERO_REG;
  - (id_use_rn & id_rn==EX.rd) or (id_use_rm & id_rm==EX.rd).
- Stall holds for exactly one cycle per load-use pair. The bubble clears the condition, so the held instruction proceeds next cycle and receives sel=10 from WB.
- The upstream IF/ID register holds its contents while stall=1. The controller does not re-sample id_* in that cycle (bubble only).
- flush and stall in the same cycle: flush wins, stall=0, bubble into EX, counter not incremented. MEM and WB are not affected by flush.
- stall_count increments on each edge where stall=1. It saturates at all-ones with no wrap.
- Reset (reset=0 at edge): all stage valid bits=0, stall_count=0. Consequently fwd_sel_a=fwd_sel_b=00 and stall=0 from the first cycle after reset.
- Reset asserted mid-stall: the pipeline records clear and no stall is issued after the reset edge.

Test Plan:
1. Reset low 2 cycles, id_valid=0 -> fwd_sel_a=fwd_sel_b=00, stall=0, stall_count=0.
2. ADD X1,X2,X3 then SUB X4,X1,X1 back-to-back -> in SUB's EX cycle fwd_sel_a=01 and fwd_sel_b=01; no stall.
3. ADD X5,.. ; NOP ; ORR X6,X5,X7 -> in ORR's EX cycle fwd_sel_a=10, fwd_sel_b=00.
4. Two writers, ADD X9 then SUB X9, followed by AND X10,X9,X9 -> sel=01 (MEM priority over WB).
5. LDUR X2,[X0] then ADD X3,X2,X4:
   - stall=1 for exactly one cycle, stall_count=1;
   - ADD's EX cycle gives fwd_sel_a=10.
   - Repeat with the destination X31 -> stall=0, sel=00.
6. Load-use condition with flush=1 the same cycle -> stall=0, EX bubble, stall_count unchanged.
   - Separately, force stall_count to all-ones via repeated load-use -> it stays all-ones.
